// File: rtl/ram_mp_delayed_if.sv
// Bus bundle for ram_mp_delayed: read ports, delayed write port and debug port.
// rvalid[i] is a one-cycle strobe with no ready: high after an edge that sampled ren[i], rdata holds otherwise.
interface ram_mp_delayed_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NRD   = 1,
  parameter int PW    = 4
);
  logic [NRD*AW-1:0]    raddr;
  logic [NRD-1:0]       ren;
  logic [NRD*WIDTH-1:0] rdata;
  logic [NRD-1:0]       rvalid;
  logic [AW-1:0]        waddr;
  logic [WIDTH-1:0]     wdata;
  logic                 wen;
  logic [PW-1:0]        wr_pending;
  logic [AW-1:0]        debug_addr;
  logic [WIDTH-1:0]     debug_data;
  logic [AW-1:0]        debug_write_addr;
  logic [WIDTH-1:0]     debug_write_data;
  logic                 debug_write_en;

  modport master (
    output raddr, ren, waddr, wdata, wen, debug_addr,
           debug_write_addr, debug_write_data, debug_write_en,
    input  rdata, rvalid, wr_pending, debug_data
  );

  modport slave (
    input  raddr, ren, waddr, wdata, wen, debug_addr,
           debug_write_addr, debug_write_data, debug_write_en,
    output rdata, rvalid, wr_pending, debug_data
  );
endinterface

// File: rtl/ram_mp_delayed.sv
// Multi-read-port RAM with a WR_DELAY-stage write pipeline, optional read-after-write
// forwarding, and a combinational debug read / immediate debug write port.
module ram_mp_delayed #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 1,
  parameter int WR_DELAY = 1,
  parameter int FORWARD  = 0,
  parameter int PW       = 4
) (
  input logic             clk,
  input logic             rst,
  ram_mp_delayed_if.slave bus
);
  localparam int LAST = WR_DELAY - 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [WR_DELAY-1:0]  pv;
  logic [AW-1:0]        pa [WR_DELAY];
  logic [WIDTH-1:0]     pd [WR_DELAY];
  logic [AW-1:0]        ra [NRD];
  logic [WIDTH-1:0]     rd_next [NRD];
  logic [NRD*WIDTH-1:0] rdata_q;
  logic [NRD-1:0]       rvalid_q;
  logic [PW-1:0]        pend_cnt;

  function automatic logic in_range(input logic [AW-1:0] a);
    if (DEPTH >= (1 << AW)) return 1'b1;
    return 32'(a) < DEPTH;
  endfunction

  // Stage 0 is the youngest write; stage LAST commits on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int k = 0; k < WR_DELAY; k++) begin
        pa[k] <= '0;
        pd[k] <= '0;
      end
    end else begin
      pv[0] <= bus.wen;
      pa[0] <= bus.waddr;
      pd[0] <= bus.wdata;
      for (int k = 1; k < WR_DELAY; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
        pd[k] <= pd[k-1];
      end
    end
  end

  // Pipeline commit is written last so it overrides a same-address debug write.
  always_ff @(posedge clk) begin
    if (bus.debug_write_en && in_range(bus.debug_write_addr))
      mem[bus.debug_write_addr] <= bus.debug_write_data;
    if (pv[LAST] && in_range(pa[LAST]))
      mem[pa[LAST]] <= pd[LAST];
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) ra[i] = bus.raddr[i*AW +: AW];
  end

  // Forwarding walks oldest to youngest so the youngest matching stage wins.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_next[i] = '0;
      if (in_range(ra[i])) begin
        rd_next[i] = mem[ra[i]];
        if (FORWARD != 0) begin
          if (bus.debug_write_en && (bus.debug_write_addr == ra[i]))
            rd_next[i] = bus.debug_write_data;
          for (int k = LAST; k >= 0; k--) begin
            if (pv[k] && (pa[k] == ra[i])) rd_next[i] = pd[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= bus.ren;
      for (int i = 0; i < NRD; i++) begin
        if (bus.ren[i]) rdata_q[i*WIDTH +: WIDTH] <= rd_next[i];
      end
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int k = 0; k < WR_DELAY; k++) pend_cnt = pend_cnt + PW'(pv[k]);
  end

  assign bus.rdata      = rdata_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.wr_pending = pend_cnt;
  assign bus.debug_data = in_range(bus.debug_addr) ? mem[bus.debug_addr] : '0;
endmodule

// File: tb/tb_ram_mp_delayed.sv
// Directed bench for ram_mp_delayed: four instances cover delay, forwarding,
// multi-port reads, commit conflict, out-of-range access and reset mid-write.
module tb_ram_mp_delayed;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_mp_delayed_if #(.WIDTH(32), .AW(5), .NRD(2), .PW(4)) ia ();
  ram_mp_delayed_if #(.WIDTH(32), .AW(5), .NRD(1), .PW(4)) ib ();
  ram_mp_delayed_if #(.WIDTH(32), .AW(5), .NRD(1), .PW(4)) id ();
  ram_mp_delayed_if #(.WIDTH(32), .AW(5), .NRD(1), .PW(4)) ic ();

  ram_mp_delayed #(.WIDTH(32), .DEPTH(32), .AW(5), .NRD(2), .WR_DELAY(3), .FORWARD(0), .PW(4))
    dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  ram_mp_delayed #(.WIDTH(32), .DEPTH(32), .AW(5), .NRD(1), .WR_DELAY(2), .FORWARD(1), .PW(4))
    dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  ram_mp_delayed #(.WIDTH(32), .DEPTH(32), .AW(5), .NRD(1), .WR_DELAY(2), .FORWARD(0), .PW(4))
    dut_d (.clk(clk), .rst(rst), .bus(id.slave));
  ram_mp_delayed #(.WIDTH(32), .DEPTH(20), .AW(5), .NRD(1), .WR_DELAY(4), .FORWARD(0), .PW(4))
    dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dbg_a(input logic [4:0] a, input logic [31:0] d);
    ia.debug_write_addr = a; ia.debug_write_data = d; ia.debug_write_en = 1'b1;
    tick();
    ia.debug_write_en = 1'b0;
  endtask

  task automatic dbg_bd(input logic [4:0] a, input logic [31:0] d);
    ib.debug_write_addr = a; ib.debug_write_data = d; ib.debug_write_en = 1'b1;
    id.debug_write_addr = a; id.debug_write_data = d; id.debug_write_en = 1'b1;
    tick();
    ib.debug_write_en = 1'b0; id.debug_write_en = 1'b0;
  endtask

  task automatic dbg_c(input logic [4:0] a, input logic [31:0] d);
    ic.debug_write_addr = a; ic.debug_write_data = d; ic.debug_write_en = 1'b1;
    tick();
    ic.debug_write_en = 1'b0;
  endtask

  task automatic wr_bd(input logic en, input logic [4:0] a, input logic [31:0] d);
    ib.wen = en; ib.waddr = a; ib.wdata = d;
    id.wen = en; id.waddr = a; id.wdata = d;
  endtask

  task automatic rd_bd(input logic en, input logic [4:0] a);
    ib.ren = en; ib.raddr = a;
    id.ren = en; id.raddr = a;
  endtask

  initial begin
    ia.raddr = '0; ia.ren = '0; ia.waddr = '0; ia.wdata = '0; ia.wen = 1'b0; ia.debug_addr = '0;
    ia.debug_write_addr = '0; ia.debug_write_data = '0; ia.debug_write_en = 1'b0;
    ib.raddr = '0; ib.ren = '0; ib.waddr = '0; ib.wdata = '0; ib.wen = 1'b0; ib.debug_addr = '0;
    ib.debug_write_addr = '0; ib.debug_write_data = '0; ib.debug_write_en = 1'b0;
    id.raddr = '0; id.ren = '0; id.waddr = '0; id.wdata = '0; id.wen = 1'b0; id.debug_addr = '0;
    id.debug_write_addr = '0; id.debug_write_data = '0; id.debug_write_en = 1'b0;
    ic.raddr = '0; ic.ren = '0; ic.waddr = '0; ic.wdata = '0; ic.wen = 1'b0; ic.debug_addr = '0;
    ic.debug_write_addr = '0; ic.debug_write_data = '0; ic.debug_write_en = 1'b0;

    // Reset with a debug preload of addr 0 = 12
    #2 rst = 1'b1;
    ia.debug_write_addr = 5'd0; ia.debug_write_data = 32'd12; ia.debug_write_en = 1'b1;
    tick();
    check("rst_rdata", ia.rdata, 0);
    check("rst_rvalid", ia.rvalid, 0);
    check("rst_pending", ia.wr_pending, 0);
    ia.debug_write_en = 1'b0;
    rst = 1'b0;
    tick();
    ia.debug_addr = 5'd0;
    #1 check("preload", ia.debug_data, 12);

    // Two read ports
    dbg_a(5'd1, 32'd3);
    dbg_a(5'd2, 32'd7);
    ia.raddr = {5'd2, 5'd1}; ia.ren = 2'b11;
    tick();
    check("rd2_data", ia.rdata, {32'd7, 32'd3});
    check("rd2_valid", ia.rvalid, 2'b11);
    ia.raddr = {5'd2, 5'd0}; ia.ren = 2'b01;
    tick();
    check("rd2_hold", ia.rdata, {32'd7, 32'd12});
    check("rd2_valid_hold", ia.rvalid, 2'b01);
    ia.raddr = {5'd1, 5'd1}; ia.ren = 2'b11;
    tick();
    check("rd2_same_addr", ia.rdata, {32'd3, 32'd3});
    ia.ren = 2'b00;

    // Delayed write with WR_DELAY=3
    dbg_a(5'd4, 32'd1);
    ia.wen = 1'b1; ia.waddr = 5'd4; ia.wdata = 32'd17;
    tick();
    ia.wen = 1'b0; ia.debug_addr = 5'd4;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      check($sformatf("dly_pend_%0d", c), ia.wr_pending, (c < 3) ? 1 : 0);
      check($sformatf("dly_data_%0d", c), ia.debug_data, (c < 3) ? 1 : 17);
    end

    // Back-to-back writes saturate wr_pending
    ia.wen = 1'b1;
    for (int c = 0; c < 5; c++) begin
      ia.waddr = 5'(10 + c); ia.wdata = 32'(100 + c);
      tick();
    end
    check("sat_pend", ia.wr_pending, 3);
    ia.wen = 1'b0;
    tick();
    check("drain_pend", ia.wr_pending, 2);
    tick();
    tick();
    check("drained_pend", ia.wr_pending, 0);
    ia.debug_addr = 5'd12;
    #1 check("b2b_commit", ia.debug_data, 102);

    // Pipeline commit and debug write to the same address on one edge
    ia.wen = 1'b1; ia.waddr = 5'd6; ia.wdata = 32'd5;
    tick();
    ia.wen = 1'b0;
    tick();
    tick();
    ia.debug_write_addr = 5'd6; ia.debug_write_data = 32'd99; ia.debug_write_en = 1'b1;
    tick();
    ia.debug_write_en = 1'b0; ia.debug_addr = 5'd6;
    #1 check("conflict", ia.debug_data, 5);

    // Forwarding (dut_b) vs read-old (dut_d), WR_DELAY=2
    dbg_bd(5'd5, 32'd1);
    dbg_bd(5'd7, 32'd3);
    wr_bd(1'b1, 5'd5, 32'd9);
    tick();
    wr_bd(1'b1, 5'd5, 32'd10);
    tick();
    wr_bd(1'b0, 5'd0, 32'd0);
    rd_bd(1'b1, 5'd5);
    tick();
    check("fwd_youngest", ib.rdata, 10);
    check("fwd_valid", ib.rvalid, 1);
    check("nofwd_old", id.rdata, 1);
    check("nofwd_valid", id.rvalid, 1);
    wr_bd(1'b1, 5'd5, 32'd20);
    tick();
    check("fwd_no_same_edge", ib.rdata, 10);
    check("nofwd_before_commit", id.rdata, 9);
    wr_bd(1'b0, 5'd0, 32'd0);
    rd_bd(1'b0, 5'd0);
    tick();
    check("fwd_hold_valid", ib.rvalid, 0);
    check("fwd_hold_data", ib.rdata, 10);
    tick();
    tick();
    ib.debug_addr = 5'd5;
    #1 check("fwd_final_array", ib.debug_data, 20);
    ib.debug_write_addr = 5'd7; ib.debug_write_data = 32'd55; ib.debug_write_en = 1'b1;
    id.debug_write_addr = 5'd7; id.debug_write_data = 32'd55; id.debug_write_en = 1'b1;
    rd_bd(1'b1, 5'd7);
    tick();
    ib.debug_write_en = 1'b0; id.debug_write_en = 1'b0;
    rd_bd(1'b0, 5'd0);
    check("fwd_debug_write", ib.rdata, 55);
    check("nofwd_debug_write", id.rdata, 3);

    // Out-of-range access on DEPTH=20
    dbg_c(5'd3, 32'd77);
    dbg_c(5'd8, 32'd1);
    ic.raddr = 5'd3; ic.ren = 1'b1;
    tick();
    check("oor_pre_read", ic.rdata, 77);
    ic.raddr = 5'd25;
    tick();
    check("oor_read", ic.rdata, 0);
    check("oor_valid", ic.rvalid, 1);
    ic.ren = 1'b0; ic.debug_addr = 5'd25;
    #1 check("oor_debug", ic.debug_data, 0);
    ic.wen = 1'b1; ic.waddr = 5'd25; ic.wdata = 32'd66;
    tick();
    ic.wen = 1'b0;
    check("oor_pend", ic.wr_pending, 1);
    for (int c = 0; c < 4; c++) tick();
    check("oor_pend_drain", ic.wr_pending, 0);

    // Reset two cycles into a WR_DELAY=4 write
    ic.wen = 1'b1; ic.waddr = 5'd8; ic.wdata = 32'd44;
    tick();
    ic.wen = 1'b0;
    check("rmw_pend", ic.wr_pending, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rmw_pend_rst", ic.wr_pending, 0);
    check("rmw_rdata_rst", ia.rdata, 0);
    check("rmw_rvalid_rst", ic.rvalid, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    ic.debug_addr = 5'd8;
    #1 check("rmw_never_commit", ic.debug_data, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
